// File: rtl/load_store_unit_if.sv
// Core/memory bundle for the load-store unit: request, response and data-memory port.
// Pure wiring, no latency of its own.
// Backpressure is carried by req_ready; the memory side has no stall.
interface load_store_unit_if;
  // core request
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  // core response
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  // data memory
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  // LSU side
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  // core + memory side
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Load-store unit: LB/LH/LW/LBU/LHU/SB/SH/SW onto a word-wide async-read memory, RMW for sub-word stores.
// Latency accept->resp_valid: error 1, load 2, word store 2, sub-word store 3 cycles.
// One op in flight; req_ready is high only in IDLE, so the core stalls for the whole op.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state;
  logic        write_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;

  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_misaligned_r;
  logic        resp_fault_r;

  logic        accept;
  logic        req_misaligned;
  logic        req_fault;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = bus.req_valid && (state == IDLE);

  // Classify the incoming request; misalignment masks the range check.
  always_comb begin
    req_misaligned = (bus.req_size == 2'b11) ||
                     ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                     ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    req_fault      = !req_misaligned && (bus.req_addr[31:2] >= 30'(MEM_WORDS));
  end

  // Lane select, load extension and store merge, all keyed off the latched request.
  always_comb begin
    lane_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_ext = unsigned_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = bus.mem_rdata;
    endcase
    merged = bus.mem_rdata;
    if (size_q == SZ_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Sequencer: latch on accept, one cycle per state, response registered on entry to RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      write_q           <= 1'b0;
      size_q            <= 2'b00;
      unsigned_q        <= 1'b0;
      addr_q            <= 32'h0;
      wdata_q           <= 32'h0;
      merged_q          <= 32'h0;
      resp_valid_r      <= 1'b0;
      resp_rdata_r      <= 32'h0;
      resp_misaligned_r <= 1'b0;
      resp_fault_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            write_q    <= bus.req_write;
            size_q     <= bus.req_size;
            unsigned_q <= bus.req_unsigned;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
            if (req_misaligned || req_fault) begin
              resp_valid_r      <= 1'b1;
              resp_rdata_r      <= 32'h0;
              resp_misaligned_r <= req_misaligned;
              resp_fault_r      <= req_fault;
              state             <= RESP;
            end else if (!bus.req_write) begin
              state <= READ;
            end else if (bus.req_size == SZ_WORD) begin
              state <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        READ: begin
          resp_valid_r      <= 1'b1;
          resp_rdata_r      <= write_q ? 32'h0 : load_ext;
          resp_misaligned_r <= 1'b0;
          resp_fault_r      <= 1'b0;
          state             <= RESP;
        end
        RMW_RD: begin
          merged_q <= merged;
          state    <= WRITE;
        end
        WRITE: begin
          resp_valid_r      <= 1'b1;
          resp_rdata_r      <= 32'h0;
          resp_misaligned_r <= 1'b0;
          resp_fault_r      <= 1'b0;
          state             <= RESP;
        end
        RESP: begin
          resp_valid_r      <= 1'b0;
          resp_rdata_r      <= 32'h0;
          resp_misaligned_r <= 1'b0;
          resp_fault_r      <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes are Moore outputs of the state so an async reset drops them immediately.
  assign bus.mem_read  = (state == READ) || (state == RMW_RD);
  assign bus.mem_write = (state == WRITE);
  assign bus.mem_addr  = ((state == READ) || (state == RMW_RD) || (state == WRITE)) ?
                         {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wdata = (state == WRITE) ? ((size_q == SZ_WORD) ? wdata_q : merged_q) : 32'h0;

  assign bus.req_ready       = (state == IDLE);
  assign bus.resp_valid      = resp_valid_r;
  assign bus.resp_rdata      = resp_rdata_r;
  assign bus.resp_misaligned = resp_misaligned_r;
  assign bus.resp_fault      = resp_fault_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word behavioural data memory.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Every wait is bounded by a cycle budget.
module tb_load_store_unit;

  logic clk;
  logic reset;
  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural memory: async read, posedge write
  logic [31:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  // activity monitor
  int          wr_cnt = 0, rd_cnt = 0, resp_cnt = 0;
  logic [31:0] last_waddr = 0, last_wdata = 0;
  time         last_rd_t = 0, last_wr_t = 0;
  always @(posedge clk) begin
    if (bus.mem_write) begin wr_cnt++; last_waddr = bus.mem_addr; last_wdata = bus.mem_wdata; last_wr_t = $time; end
    if (bus.mem_read) begin rd_cnt++; last_rd_t = $time; end
    if (bus.resp_valid) resp_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Issues one request from a falling edge; returns at the falling edge where resp_valid is seen.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic mis, output logic flt);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = bus.resp_rdata; mis = bus.resp_misaligned; flt = bus.resp_fault;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_strobes: got r%b w%b want 0 0", bus.mem_read, bus.mem_write); end
    n_cmp++; if (bus.mem_addr !== 32'h0 || bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_zero_buses: got addr %h rdata %h want 0 0", bus.mem_addr, bus.resp_rdata); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    int lat; logic [31:0] rd; logic mis, flt; int w0;
    w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, lat, rd, mis, flt);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL sw_write_count: got %0d want 1", wr_cnt - w0); end
    n_cmp++; if (last_waddr !== 32'h40 || last_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_write_bus: got %h/%h want 00000040/deadbeef", last_waddr, last_wdata); end
    n_cmp++; if (rd !== 32'h0 || mis !== 1'b0 || flt !== 1'b0) begin n_bad++; $display("FAIL sw_resp: got %h m%b f%b want 0 0 0", rd, mis, flt); end
  endtask

  task automatic test_subword_store();
    int lat; logic [31:0] rd; logic mis, flt; int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AA, lat, rd, mis, flt);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sb_latency: got %0d want 3", lat); end
    n_cmp++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL sb_strobes: got rd %0d wr %0d want 1 1", rd_cnt - r0, wr_cnt - w0); end
    n_cmp++; if (!(last_rd_t < last_wr_t)) begin n_bad++; $display("FAIL sb_order: got read@%0t write@%0t want read first", last_rd_t, last_wr_t); end
    n_cmp++; if (last_wdata !== 32'hDEADAAEF) begin n_bad++; $display("FAIL sb_merged: got %h want deadaaef", last_wdata); end
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, mis, flt);
    n_cmp++; if (rd !== 32'hDEADAAEF || lat !== 2) begin n_bad++; $display("FAIL lw_after_sb: got %h lat %0d want deadaaef lat 2", rd, lat); end
  endtask

  task automatic test_load_extend();
    int lat; logic [31:0] rd; logic mis, flt;
    logic [1:0]  sz  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    logic        un  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad  [6] = '{32'h41, 32'h41, 32'h42, 32'h42, 32'h43, 32'h40};
    logic [31:0] exp [6] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFDE, 32'hFFFFAAEF};
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, mis, flt);
      n_cmp++; if (rd !== exp[i] || mis !== 1'b0 || flt !== 1'b0) begin n_bad++; $display("FAIL load_ext_%0d: got %h m%b f%b want %h 0 0", i, rd, mis, flt, exp[i]); end
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic mis, flt; int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, rd, mis, flt);
    n_cmp++; if (mis !== 1'b1 || flt !== 1'b0 || rd !== 32'h0 || lat !== 1) begin n_bad++; $display("FAIL lw_misaligned: got m%b f%b %h lat %0d want 1 0 0 lat 1", mis, flt, rd, lat); end
    n_cmp++; if (rd_cnt != r0 || wr_cnt != w0) begin n_bad++; $display("FAIL lw_misaligned_mem: got rd %0d wr %0d want 0 0", rd_cnt - r0, wr_cnt - w0); end
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h11111111, lat, rd, mis, flt);
    n_cmp++; if (flt !== 1'b1 || mis !== 1'b0 || lat !== 1 || wr_cnt != w0) begin n_bad++; $display("FAIL sw_fault: got f%b m%b lat %0d wr %0d want 1 0 1 0", flt, mis, lat, wr_cnt - w0); end
    do_req(1'b1, 2'b01, 1'b0, 32'h101, 32'h2222, lat, rd, mis, flt);
    n_cmp++; if (mis !== 1'b1 || flt !== 1'b0) begin n_bad++; $display("FAIL mis_priority: got m%b f%b want 1 0", mis, flt); end
    do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, lat, rd, mis, flt);
    n_cmp++; if (mis !== 1'b1 || rd_cnt != r0) begin n_bad++; $display("FAIL size_reserved: got m%b rd %0d want 1 0", mis, rd_cnt - r0); end
    do_req(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, lat, rd, mis, flt);
    n_cmp++; if (flt !== 1'b0 || mis !== 1'b0 || lat !== 2) begin n_bad++; $display("FAIL last_word_ok: got f%b m%b lat %0d want 0 0 2", flt, mis, lat); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic mis, flt; int w0, v0;
    w0 = wr_cnt; v0 = resp_cnt;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL abort_in_rmw: got r%b w%b want 1 0", bus.mem_read, bus.mem_write); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL abort_strobes: got r%b w%b want 0 0", bus.mem_read, bus.mem_write); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_cnt != w0 || resp_cnt != v0) begin n_bad++; $display("FAIL abort_no_effect: got wr %0d resp %0d want 0 0", wr_cnt - w0, resp_cnt - v0); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", bus.req_ready); end
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, mis, flt);
    n_cmp++; if (rd !== 32'hDEADAAEF) begin n_bad++; $display("FAIL abort_word_kept: got %h want deadaaef", rd); end
  endtask

  task automatic test_back_to_back();
    int w0, v0;
    w0 = wr_cnt; v0 = resp_cnt;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_addr = 32'h44; bus.req_wdata = 32'h12345678;
    @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADAAEF) begin n_bad++; $display("FAIL b2b_first: got v%b %h want 1 deadaaef", bus.resp_valid, bus.resp_rdata); end
    n_cmp++; if (bus.req_ready !== 1'b0 || wr_cnt != w0) begin n_bad++; $display("FAIL b2b_no_overlap: got ready %b wr %0d want 0 0", bus.req_ready, wr_cnt - w0); end
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got ready %b v%b want 1 0", bus.req_ready, bus.resp_valid); end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b1 || wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL b2b_second: got v%b wr %0d want 1 1", bus.resp_valid, wr_cnt - w0); end
    n_cmp++; if (last_waddr !== 32'h44 || last_wdata !== 32'h12345678 || resp_cnt - v0 !== 1) begin n_bad++; $display("FAIL b2b_second_bus: got %h/%h resp %0d want 00000044/12345678 1", last_waddr, last_wdata, resp_cnt - v0); end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_word_store();
    test_subword_store();
    test_load_extend();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
